// File: rtl/att_controller.sv
// att_controller: loads a literal-to-clause table into an external RAM and
// serves single-outstanding lookups for two round-robin arbitrated requesters.
//
// Handshakes: a load beat transfers on a rising edge where load_valid_i and
// load_ready_o are both high; a request from requester k transfers on an edge
// where req_valid_i[k] and req_ready_o[k] are both high; a response transfers
// on an edge where rsp_valid_o and rsp_ready_i are both high. A valid source
// holds its payload stable until the transfer, and ready never depends on
// anything but state and the inputs sampled that cycle.
module att_controller #(
  parameter int CLAUSE_COUNT               = 20,
  parameter int VARIABLE_ADDRESS_WIDTH     = 11,
  parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               load_start_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]                    load_count_i,
  input  logic                                               load_valid_i,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] load_data_i,
  output logic                                               load_ready_o,
  output logic                                               load_done_o,
  input  logic [1:0]                                         req_valid_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]                    req_lit0_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]                    req_lit1_i,
  output logic [1:0]                                         req_ready_o,
  output logic                                               rsp_valid_o,
  input  logic                                               rsp_ready_i,
  output logic                                               rsp_id_o,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]              rsp_addr_o,
  output logic [CLAUSE_COUNT-1:0]                            rsp_mask_o,
  output logic                                               rsp_err_o,
  output logic                                               tbl_wr_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH:0]                    tbl_wr_addr_o,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] tbl_data_o,
  output logic [VARIABLE_ADDRESS_WIDTH:0]                    tbl_rd_addr_o,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]              tbl_addr_i,
  input  logic [CLAUSE_COUNT-1:0]                            tbl_mask_i,
  output logic [2:0]                                         dbg_state_o
);

  localparam int VAW = VARIABLE_ADDRESS_WIDTH;
  localparam int CAW = CLAUSE_TABLE_ADDRESS_WIDTH;
  localparam int W   = CAW + CLAUSE_COUNT;
  // DEPTH = 2**VAW expressed directly in the literal index width
  localparam logic [VAW:0] DEPTH_L = {1'b1, {VAW{1'b0}}};

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t       state;
  logic [VAW:0] load_n;
  logic [VAW:0] wr_ptr;
  logic [VAW:0] loaded_count;
  logic         prio;
  logic         err_q;

  logic [1:0]   grant;
  logic [VAW:0] lit_sel;
  logic [VAW:0] load_n_clamped;

  assign dbg_state_o = state;
  assign req_ready_o = grant;

  // Round-robin grant: only in READY and only when no load is starting
  always_comb begin
    grant = 2'b00;
    if (rst_n && (state == ST_READY) && !load_start_i) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Literal of the granted requester and the clamped load length
  always_comb begin
    lit_sel        = grant[1] ? req_lit1_i : req_lit0_i;
    load_n_clamped = (load_count_i > DEPTH_L) ? DEPTH_L : load_count_i;
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_READY;
      load_n        <= '0;
      wr_ptr        <= '0;
      loaded_count  <= '0;
      prio          <= 1'b0;
      err_q         <= 1'b0;
      load_ready_o  <= 1'b0;
      load_done_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= 1'b0;
      rsp_addr_o    <= '0;
      rsp_mask_o    <= '0;
      rsp_err_o     <= 1'b0;
      tbl_wr_en_o   <= 1'b0;
      tbl_wr_addr_o <= '0;
      tbl_data_o    <= '0;
      tbl_rd_addr_o <= '0;
    end else begin
      tbl_wr_en_o <= 1'b0;
      load_done_o <= 1'b0;
      case (state)
        ST_READY: begin
          if (load_start_i) begin
            load_n       <= load_n_clamped;
            wr_ptr       <= '0;
            loaded_count <= '0;
            if (load_n_clamped == '0) begin
              load_done_o <= 1'b1;
            end else begin
              load_ready_o <= 1'b1;
              state        <= ST_LOAD;
            end
          end else if (grant != 2'b00) begin
            tbl_rd_addr_o <= lit_sel;
            rsp_id_o      <= grant[1];
            // loaded_count never exceeds DEPTH, the second term keeps the
            // out-of-table case explicit
            err_q         <= (lit_sel >= loaded_count) || (lit_sel >= DEPTH_L);
            if (req_valid_i == 2'b11) prio <= ~grant[1];
            state         <= ST_ISSUE;
          end
        end
        ST_LOAD: begin
          if (load_valid_i && load_ready_o) begin
            tbl_wr_en_o   <= 1'b1;
            tbl_wr_addr_o <= wr_ptr;
            tbl_data_o    <= load_data_i;
            wr_ptr        <= wr_ptr + 1'b1;
            if (wr_ptr == load_n - 1'b1) begin
              loaded_count <= load_n;
              load_ready_o <= 1'b0;
              load_done_o  <= 1'b1;
              state        <= ST_READY;
            end
          end
        end
        ST_ISSUE: begin
          // RAM samples tbl_rd_addr_o on this edge
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= err_q;
          rsp_addr_o  <= err_q ? '0 : tbl_addr_i;
          rsp_mask_o  <= err_q ? '0 : tbl_mask_i;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_READY;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_att_controller.sv
// tb_att_controller: self-checking bench for att_controller with a behavioural
// table/arbiter model and a one-cycle-latency RAM attached to the table port.
module tb_att_controller;

  localparam int CC    = 20;
  localparam int VAW   = 11;
  localparam int CAW   = 11;
  localparam int W     = CAW + CC;
  localparam int RW    = 2 + W;
  localparam int DEPTH = 2 ** VAW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           load_start_i = 1'b0;
  logic [VAW:0]   load_count_i = '0;
  logic           load_valid_i = 1'b0;
  logic [W-1:0]   load_data_i = '0;
  logic           load_ready_o;
  logic           load_done_o;
  logic [1:0]     req_valid_i = '0;
  logic [VAW:0]   req_lit0_i = '0;
  logic [VAW:0]   req_lit1_i = '0;
  logic [1:0]     req_ready_o;
  logic           rsp_valid_o;
  logic           rsp_ready_i = 1'b0;
  logic           rsp_id_o;
  logic [CAW-1:0] rsp_addr_o;
  logic [CC-1:0]  rsp_mask_o;
  logic           rsp_err_o;
  logic           tbl_wr_en_o;
  logic [VAW:0]   tbl_wr_addr_o;
  logic [W-1:0]   tbl_data_o;
  logic [VAW:0]   tbl_rd_addr_o;
  logic [CAW-1:0] tbl_addr_i;
  logic [CC-1:0]  tbl_mask_i;
  logic [2:0]     dbg_state;

  att_controller #(
    .CLAUSE_COUNT(CC), .VARIABLE_ADDRESS_WIDTH(VAW), .CLAUSE_TABLE_ADDRESS_WIDTH(CAW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(load_start_i), .load_count_i(load_count_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .req_valid_i(req_valid_i), .req_lit0_i(req_lit0_i), .req_lit1_i(req_lit1_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_addr_o(rsp_addr_o), .rsp_mask_o(rsp_mask_o), .rsp_err_o(rsp_err_o),
    .tbl_wr_en_o(tbl_wr_en_o), .tbl_wr_addr_o(tbl_wr_addr_o), .tbl_data_o(tbl_data_o),
    .tbl_rd_addr_o(tbl_rd_addr_o), .tbl_addr_i(tbl_addr_i), .tbl_mask_i(tbl_mask_i),
    .dbg_state_o(dbg_state)
  );

  // external table RAM, one-cycle read latency
  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] rd_q;
  always @(posedge clk) begin
    if (tbl_wr_en_o) ram[tbl_wr_addr_o[VAW-1:0]] <= tbl_data_o;
    rd_q <= ram[tbl_rd_addr_o[VAW-1:0]];
  end
  assign tbl_addr_i = rd_q[W-1:CC];
  assign tbl_mask_i = rd_q[CC-1:0];

  // reference model
  logic [W-1:0]  model_tbl [DEPTH];
  int            model_loaded = 0;
  int            model_prio = 0;
  logic [RW-1:0] exp_q [$];

  int checks = 0;
  int failures = 0;

  function automatic logic [RW-1:0] model_rsp(input int id, input int lit);
    logic [W-1:0] zero_e;
    zero_e = '0;
    if (lit >= model_loaded) return {id[0], 1'b1, zero_e};
    return {id[0], 1'b0, model_tbl[lit]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 2'b11;
    tick();
    tick();
    checks++;
    if (req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", req_ready_o);
    end
    checks++;
    if ({load_ready_o, load_done_o, rsp_valid_o, rsp_id_o, rsp_addr_o, rsp_mask_o, rsp_err_o,
         tbl_wr_en_o, tbl_wr_addr_o, tbl_data_o, tbl_rd_addr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got lr=%b ld=%b rv=%b id=%b a=%h m=%h e=%b we=%b wa=%h wd=%h ra=%h exp=all zero",
               load_ready_o, load_done_o, rsp_valid_o, rsp_id_o, rsp_addr_o, rsp_mask_o, rsp_err_o,
               tbl_wr_en_o, tbl_wr_addr_o, tbl_data_o, tbl_rd_addr_o);
    end
    req_valid_i = 2'b00;
    rst_n = 1'b1;
    model_loaded = 0;
    model_prio = 0;
  endtask

  task automatic test_load(input int n, input int stall_at, input bit with_req);
    int nn;
    logic [W-1:0] d;
    nn = (n > DEPTH) ? DEPTH : n;
    load_start_i = 1'b1;
    load_count_i = n[VAW:0];
    if (with_req) begin
      req_valid_i = 2'b11;
      req_lit0_i = 12'($urandom_range(0, 3));
      req_lit1_i = 12'($urandom_range(0, 3));
      checks++;
      if (req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL load_start_wins got=%b exp=00", req_ready_o);
      end
    end
    tick();
    load_start_i = 1'b0;
    req_valid_i = 2'b00;
    model_loaded = 0;
    if (nn == 0) begin
      checks++;
      if ({load_done_o, load_ready_o} !== 2'b10) begin
        failures++;
        $display("FAIL load_zero got done=%b ready=%b exp done=1 ready=0", load_done_o, load_ready_o);
      end
      tick();
      checks++;
      if (load_done_o !== 1'b0) begin
        failures++;
        $display("FAIL load_zero_pulse got=%b exp=0", load_done_o);
      end
      return;
    end
    checks++;
    if ({load_ready_o, load_done_o} !== 2'b10) begin
      failures++;
      $display("FAIL load_enter got ready=%b done=%b exp ready=1 done=0", load_ready_o, load_done_o);
    end
    for (int b = 0; b < nn; b++) begin
      if (b == stall_at) begin
        load_valid_i = 1'b0;
        load_data_i = W'($urandom());
        tick();
        checks++;
        if ({tbl_wr_en_o, load_ready_o} !== 2'b01) begin
          failures++;
          $display("FAIL load_stall got we=%b ready=%b exp we=0 ready=1", tbl_wr_en_o, load_ready_o);
        end
      end
      d = W'($urandom());
      model_tbl[b] = d;
      load_valid_i = 1'b1;
      load_data_i = d;
      tick();
      checks++;
      if ({tbl_wr_en_o, tbl_wr_addr_o, tbl_data_o} !== {1'b1, 12'(b), d}) begin
        failures++;
        $display("FAIL load_write got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                 tbl_wr_en_o, tbl_wr_addr_o, tbl_data_o, b, d);
      end
      checks++;
      if ({load_done_o, load_ready_o} !== {(b == nn - 1), (b != nn - 1)}) begin
        failures++;
        $display("FAIL load_done_timing beat=%0d got done=%b ready=%b", b, load_done_o, load_ready_o);
      end
    end
    load_valid_i = 1'b0;
    model_loaded = nn;
    tick();
    checks++;
    if ({load_done_o, tbl_wr_en_o} !== 2'b00) begin
      failures++;
      $display("FAIL load_after got done=%b we=%b exp 0 0", load_done_o, tbl_wr_en_o);
    end
  endtask

  // single requester lookup; optionally holds the response for `hold` cycles
  task automatic test_lookup(input int id, input int lit, input int hold);
    logic [RW-1:0] exp;
    exp = model_rsp(id, lit);
    req_valid_i = 2'(1 << id);
    if (id == 0) begin
      req_lit0_i = lit[VAW:0];
      req_lit1_i = 12'($urandom());
    end else begin
      req_lit1_i = lit[VAW:0];
      req_lit0_i = 12'($urandom());
    end
    checks++;
    if (req_ready_o !== 2'(1 << id)) begin
      failures++;
      $display("FAIL lookup_grant got=%b exp=%b", req_ready_o, 2'(1 << id));
    end
    tick();
    req_valid_i = 2'b00;
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL lookup_early_valid got=%b exp=0", rsp_valid_o);
    end
    tick();
    checks++;
    if ({rsp_valid_o, rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL lookup_rsp lit=%0d got v=%b id=%b e=%b a=%h m=%h exp v=1 rsp=%h",
               lit, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      req_valid_i = 2'b11;
      checks++;
      if (req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL hold_no_grant got=%b exp=00", req_ready_o);
      end
      tick();
      checks++;
      if ({rsp_valid_o, rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%b id=%b e=%b a=%h m=%h exp rsp=%h",
                 h, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o, exp);
      end
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL lookup_release got=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int grants;
    int exp_g;
    grants = 0;
    exp_q.delete();
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 80 && (grants < 6 || exp_q.size() != 0); cyc++) begin
      if (grants >= 6) req_valid_i = 2'b00;
      req_lit0_i = 12'($urandom_range(0, 5));
      req_lit1_i = 12'($urandom_range(0, 5));
      if (rsp_valid_o && exp_q.size() != 0) begin
        checks++;
        if ({rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o} !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_rsp got id=%b e=%b a=%h m=%h exp=%h",
                   rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (req_ready_o != 2'b00) begin
        exp_g = (model_prio == 1) ? 2 : 1;
        checks++;
        if (req_ready_o !== 2'(exp_g)) begin
          failures++;
          $display("FAIL b2b_grant n=%0d got=%b exp=%b", grants, req_ready_o, 2'(exp_g));
        end
        model_prio = (exp_g == 1) ? 1 : 0;
        exp_q.push_back(model_rsp(exp_g - 1, (exp_g == 1) ? int'(req_lit0_i) : int'(req_lit1_i)));
        grants++;
      end
      tick();
    end
    checks++;
    if (grants < 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_timeout got grants=%0d pending=%0d exp grants=6 pending=0", grants, exp_q.size());
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b0;
    tick();
  endtask

  // random traffic checked against a cycle-timed request/response model
  task automatic test_random(input int ncyc);
    bit busy;
    int age;
    bit hs;
    logic [1:0] exp_g;
    bit exp_rv;
    busy = 0;
    age = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < ncyc + 12; cyc++) begin
      if (cyc < ncyc) begin
        req_valid_i = 2'($urandom_range(0, 3));
        rsp_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b1;
      end
      req_lit0_i = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(DEPTH, 2 * DEPTH - 1))
                                                : 12'($urandom_range(0, model_loaded + 2));
      req_lit1_i = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(DEPTH, 2 * DEPTH - 1))
                                                : 12'($urandom_range(0, model_loaded + 2));
      exp_g = 2'b00;
      if (!busy) begin
        if (req_valid_i == 2'b11) exp_g = (model_prio == 1) ? 2'b10 : 2'b01;
        else exp_g = req_valid_i;
      end
      exp_rv = busy && (age >= 3);
      checks++;
      if (req_ready_o !== exp_g) begin
        failures++;
        $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_g);
      end
      checks++;
      if (rsp_valid_o !== exp_rv) begin
        failures++;
        $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid_o, exp_rv);
      end
      hs = exp_rv && rsp_ready_i;
      if (hs && exp_q.size() != 0) begin
        checks++;
        if ({rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o} !== exp_q[0]) begin
          failures++;
          $display("FAIL rand_rsp cyc=%0d got id=%b e=%b a=%h m=%h exp=%h",
                   cyc, rsp_id_o, rsp_err_o, rsp_addr_o, rsp_mask_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (exp_g != 2'b00) begin
        if (req_valid_i == 2'b11) model_prio = exp_g[1] ? 0 : 1;
        exp_q.push_back(model_rsp(exp_g[1], exp_g[1] ? int'(req_lit1_i) : int'(req_lit0_i)));
      end
      tick();
      if (hs) busy = 0;
      if (exp_g != 2'b00) begin
        busy = 1;
        age = 1;
      end else if (busy) begin
        age++;
      end
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_abort();
    // reset in the middle of a load
    load_start_i = 1'b1;
    load_count_i = 12'd5;
    tick();
    load_start_i = 1'b0;
    load_valid_i = 1'b1;
    load_data_i = W'($urandom());
    tick();
    tick();
    load_valid_i = 1'b0;
    test_reset();
    test_lookup(0, 0, 0);
    // reset while a response is waiting
    test_load(3, -1, 0);
    req_valid_i = 2'b10;
    req_lit1_i = 12'd1;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    checks++;
    if (rsp_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_reach_resp got=%b exp=1", rsp_valid_o);
    end
    test_reset();
    req_valid_i = 2'b11;
    checks++;
    if (req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL abort_prio_reset got=%b exp=01", req_ready_o);
    end
    req_valid_i = 2'b00;
    test_lookup(1, 1, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lookup(0, 0, 0);            // lookup before any load
    test_load(0, -1, 0);             // empty load
    test_load(4, 2, 0);              // stalled mid-stream
    test_lookup(1, 2, 0);
    test_lookup(0, 3, 0);
    test_lookup(0, 4, 0);            // lit == loaded_count
    test_lookup(1, DEPTH, 0);        // lit == DEPTH
    test_lookup(0, 2 * DEPTH - 1, 0);
    test_back_to_back();
    test_lookup(0, 1, 5);            // response held, no new grant
    test_load(2, -1, 1);             // load wins over a simultaneous request
    test_random(300);
    test_load(DEPTH + 3, 100, 0);    // length clamped to DEPTH
    test_lookup(1, DEPTH - 1, 0);
    test_lookup(0, DEPTH, 0);
    test_random(150);
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
